// File: rtl/idu_issue_stage.sv
// Issue stage between decoder and CU: holds one decoded instruction, presents it to the ALU for a cycle, then issues it to the CU.
// IDU_OVERRIDE_EN: forward-override flags generated; undefined: flags are 00 and a dependent instruction waits 2 extra PRESENT cycles.
module idu_issue_stage (
  input  logic        soc_clk,
  input  logic        reset,
  input  logic        dec_valid,
  input  logic [5:0]  dec_instr_cu,
  input  logic [4:0]  dec_instr_alu,
  input  logic [31:0] dec_imm,
  input  logic [4:0]  dec_rd,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_shamt,
  input  logic [31:0] dec_pc_increment,
  input  logic        dec_writes_rd,
  input  logic        dec_is_jump,
  output logic        dec_accept,
  input  logic        CU_ack,
  input  logic        CU_jump_done,
  input  logic        CU_flush,
  output logic        IDU_ready,
  output logic [5:0]  Instruction_to_CU,
  output logic [4:0]  Instruction_to_ALU,
  output logic [31:0] imm,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  shamt,
  output logic [31:0] pc_increment,
  output logic [1:0]  pipeline_override
);

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_ISSUE} state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [5:0]  r_cu;
  logic [4:0]  r_alu;
  logic [31:0] r_imm;
  logic [4:0]  r_rd;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [4:0]  r_shamt;
  logic [31:0] r_pc_inc;
  logic        r_writes_rd;
  logic        r_is_jump;
  logic [4:0]  r_last_rd;
  logic        r_jump_lock;
`ifdef IDU_OVERRIDE_EN
  logic [1:0]  r_ovr;
`else
  logic [1:0]  r_wait;
`endif

  logic        w_ack;
  logic [4:0]  w_ack_rd;
  logic        w_lock;
  logic        w_slot;
  logic        w_capture;
  logic [4:0]  w_cmp_rd;
  logic [1:0]  w_match;

  always_comb begin
    w_ack     = CU_ack && (r_state == S_ISSUE);
    w_ack_rd  = (r_writes_rd && (r_rd != 5'd0)) ? r_rd : 5'd0;
    // A jump_done pulse lifts the lock in the same cycle it arrives
    w_lock    = r_jump_lock && !CU_jump_done;
    w_slot    = (r_state == S_IDLE) || (w_ack && !r_is_jump);
    w_capture = !reset && !CU_flush && dec_valid && !w_lock && w_slot;
    // Same-cycle ack+capture compares against the instruction leaving now
    w_cmp_rd  = w_ack ? w_ack_rd : r_last_rd;
    w_match[0] = (w_cmp_rd != 5'd0) && (dec_rs1 == w_cmp_rd);
    w_match[1] = (w_cmp_rd != 5'd0) && (dec_rs2 == w_cmp_rd);
  end

  always_ff @(posedge soc_clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (CU_flush) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (w_capture) w_next_state = S_PRESENT;
`ifdef IDU_OVERRIDE_EN
        S_PRESENT: w_next_state = S_ISSUE;
`else
        S_PRESENT: if (r_wait == 2'd0) w_next_state = S_ISSUE;
`endif
        S_ISSUE:   if (w_ack) w_next_state = w_capture ? S_PRESENT : S_IDLE;
        default:   w_next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge soc_clk) begin
    if (reset || CU_flush) begin
      r_cu        <= '0;
      r_alu       <= '0;
      r_imm       <= '0;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_shamt     <= '0;
      r_pc_inc    <= '0;
      r_writes_rd <= 1'b0;
      r_is_jump   <= 1'b0;
      r_last_rd   <= '0;
      r_jump_lock <= 1'b0;
`ifdef IDU_OVERRIDE_EN
      r_ovr       <= '0;
`else
      r_wait      <= '0;
`endif
    end else begin
      if (w_capture) begin
        r_cu        <= dec_instr_cu;
        r_alu       <= dec_instr_alu;
        r_imm       <= dec_imm;
        r_rd        <= dec_rd;
        r_rs1       <= dec_rs1;
        r_rs2       <= dec_rs2;
        r_shamt     <= dec_shamt;
        r_pc_inc    <= dec_pc_increment;
        r_writes_rd <= dec_writes_rd;
        r_is_jump   <= dec_is_jump;
      end
`ifdef IDU_OVERRIDE_EN
      if (w_capture) r_ovr <= w_match;
`else
      // Without forwarding, a dependent instruction waits for the writer to retire
      if (w_capture) begin
        r_wait <= (|w_match) ? 2'd2 : 2'd0;
      end else if ((r_state == S_PRESENT) && (r_wait != 2'd0)) begin
        r_wait <= r_wait - 2'd1;
      end
`endif
      if (w_ack) r_last_rd <= w_ack_rd;
      if (w_ack && r_is_jump) begin
        r_jump_lock <= 1'b1;
      end else if (CU_jump_done) begin
        r_jump_lock <= 1'b0;
      end
    end
  end

  always_comb begin
    dec_accept         = w_capture;
    IDU_ready          = (r_state == S_ISSUE);
    Instruction_to_CU  = r_cu;
    Instruction_to_ALU = r_alu;
    imm                = r_imm;
    rd                 = r_rd;
    rs1                = r_rs1;
    rs2                = r_rs2;
    shamt              = r_shamt;
    pc_increment       = r_pc_inc;
`ifdef IDU_OVERRIDE_EN
    pipeline_override  = r_ovr;
`else
    pipeline_override  = 2'b00;
`endif
  end

endmodule
